// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int idx_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, with wrap-around.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam logic [PW:0] NUM_W = (PW+1)'(N);

    logic [PW:0]   w_sum;
    logic [PW:0]   w_cand;
    logic          w_hit;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        w_hit  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum  = {1'b0, i_ptr} + (PW+1)'(k);
            w_cand = (w_sum >= NUM_W) ? (w_sum - NUM_W) : w_sum;
            w_hit  = i_req[w_cand[PW-1:0]];
            o_pick = w_hit ? (N'(1'b1) << w_cand[PW-1:0]) : o_pick;
            o_idx  = w_hit ? w_cand[PW-1:0] : o_idx;
            o_any  = o_any | w_hit;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between byte-stream requesters,
// holding each grant for a whole burst and optionally prefixing a channel-ID header byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         DATA_BITS = 8,
    parameter int         MAX_BURST = 16,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_fifo_full,
    output logic                           tx_fifo_wr_en,
    output logic [DATA_BITS-1:0]           tx_fifo_din,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           burst_cut
);

    localparam int             PW       = idx_width(NUM_REQ);
    localparam int             CW       = idx_width(MAX_BURST);
    localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_BURST - 1);
    localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_REQ - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_idx;
    logic [CW-1:0]        r_count;
    logic                 r_burst_cut;

    logic [NUM_REQ-1:0]   w_pick;
    logic [PW-1:0]        w_pick_idx;
    logic                 w_any;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [DATA_BITS-1:0] w_sel_data;
    logic [DATA_BITS-1:0] w_hdr_byte;
    logic                 w_xfer;
    logic                 w_end;

    uart_tx_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    assign w_sel_valid = req_valid[r_idx];
    assign w_sel_last  = req_last[r_idx];
    assign w_sel_data  = req_data[r_idx*DATA_BITS +: DATA_BITS];
    assign w_hdr_byte  = DATA_BITS'(HDR_BASE) | DATA_BITS'(r_idx);
    assign w_xfer      = (r_state == ST_DATA) & w_sel_valid & ~tx_fifo_full;
    // Header bytes never reach w_xfer, so they are not counted against MAX_BURST.
    assign w_end       = w_xfer & (w_sel_last | (r_count == LAST_CNT));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_any ? (HDR_EN ? ST_HDR : ST_DATA) : ST_IDLE;
            ST_HDR:  w_state_nxt = tx_fifo_full ? ST_HDR : ST_DATA;
            ST_DATA: w_state_nxt = w_end ? ST_IDLE : ST_DATA;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, pointer, beat counter and cut-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_burst_cut <= 1'b0;
        end else begin
            r_burst_cut <= w_end & ~w_sel_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_count <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_count <= r_count + CW'(1);
                    end
                    if (w_end) begin
                        r_grant <= '0;
                        r_ptr   <= (r_idx == LAST_IDX) ? '0 : (r_idx + PW'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM outputs: FIFO write strobe/data and per-requester ready.
    always_comb begin
        req_ready     = '0;
        tx_fifo_wr_en = 1'b0;
        tx_fifo_din   = '0;
        case (r_state)
            ST_HDR: begin
                tx_fifo_wr_en = ~tx_fifo_full;
                tx_fifo_din   = w_hdr_byte;
            end
            ST_DATA: begin
                req_ready[r_idx] = ~tx_fifo_full;
                tx_fifo_wr_en    = w_sel_valid & ~tx_fifo_full;
                tx_fifo_din      = w_sel_data;
            end
            default: begin
                req_ready     = '0;
                tx_fifo_wr_en = 1'b0;
                tx_fifo_din   = '0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign burst_cut = r_burst_cut;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (4 requesters, MAX_BURST=4, headers on).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_din;
    logic [3:0]  grant;
    logic        busy;
    logic        burst_cut;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_BITS (8),
        .MAX_BURST (4),
        .HDR_EN    (1'b1),
        .HDR_BASE  (8'hA0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .tx_fifo_din   (tx_fifo_din),
        .grant         (grant),
        .busy          (busy),
        .burst_cut     (burst_cut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]  src_q [4][$];
    logic [11:0] exp_q [$];
    bit          en [4];
    bit          fire [4];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cut_cnt = 0;
    bit          bubble_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_src(input int ch, input logic [7:0] d, input logic l);
        src_q[ch].push_back({l, d});
    endtask

    task automatic expect_w(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_drain(input string name, output int busy_cyc);
        bit done = 1'b0;
        busy_cyc = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d writes still pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_byte(input logic [7:0] val);
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (tx_fifo_wr_en && tx_fifo_din == val) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_byte_timeout: byte %0h never written", val);
        end
    endtask

    // Requester model: pop accepted bytes after each edge, then present the next head.
    initial begin
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic [8:0]  tmp;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
            end
            #1;
            v = 4'b0000;
            l = 4'b0000;
            d = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (en[i] && src_q[i].size() > 0) begin
                    v[i] = 1'b1;
                    l[i] = src_q[i][0][8];
                    d[i*8 +: 8] = src_q[i][0][7:0];
                end
            end
            req_valid = v;
            req_last  = l;
            req_data  = d;
        end
    end

    // Monitor: scoreboard compare on every FIFO write, cut counting, bubble length.
    initial begin
        logic [11:0] e;
        bit prev_busy = 1'b0;
        bit seen = 1'b0;
        int idle_run = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) fire[i] = rst_n && req_valid[i] && req_ready[i];
            if (rst_n && tx_fifo_wr_en) begin
                check("wr_en_while_full", {31'd0, tx_fifo_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got din %0h grant %0h, expected no write", tx_fifo_din, grant);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din", {24'd0, tx_fifo_din}, {24'd0, e[7:0]});
                    check("grant_at_write", {28'd0, grant}, {28'd0, e[11:8]});
                end
            end
            if (burst_cut) cut_cnt++;
            if (busy && !prev_busy) begin
                if (bubble_chk && seen) check("idle_bubble", idle_run, 32'd1);
                seen = bubble_chk;
                idle_run = 0;
            end
            if (!busy) idle_run++;
            prev_busy = busy;
        end
    end

    // Directed stimulus; every push to a requester is paired with its expected FIFO writes.
    initial begin
        int bc;
        int cut0;
        int left;
        rst_n = 1'b0;
        tx_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        check("rst_din", {24'd0, tx_fifo_din}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_cut", {31'd0, burst_cut}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four valid, 1-byte bursts: order 0,1,2,3,0,1,2,3 with one idle cycle between.
        @(posedge clk);
        #1;
        bubble_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_src(i, 8'(8'h10 + i), 1'b1);
            push_src(i, 8'(8'h20 + i), 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                expect_w(4'b0001 << i, 8'(8'hA0 + i));
                expect_w(4'b0001 << i, 8'(8'h10 + 16 * r + i));
            end
        end
        wait_drain("round_robin", bc);
        bubble_chk = 1'b0;
        check("rr_busy_cycles", bc, 32'd16);

        // Single requester 2: header A2 then 11,22,33.
        @(posedge clk);
        #1;
        cut0 = cut_cnt;
        push_src(2, 8'h11, 1'b0);
        push_src(2, 8'h22, 1'b0);
        push_src(2, 8'h33, 1'b1);
        expect_w(4'b0100, 8'hA2);
        expect_w(4'b0100, 8'h11);
        expect_w(4'b0100, 8'h22);
        expect_w(4'b0100, 8'h33);
        wait_drain("single", bc);
        check("single_busy_cycles", bc, 32'd4);
        check("single_cut", cut_cnt - cut0, 32'd0);
        check("single_grant_after", {28'd0, grant}, 32'd0);

        // Requester 0 streams 10 bytes (last on the 10th) against MAX_BURST=4; requester 1 interleaves.
        @(posedge clk);
        #1;
        cut0 = cut_cnt;
        for (int b = 0; b < 10; b++) push_src(0, 8'(8'h40 + b), (b == 9) ? 1'b1 : 1'b0);
        push_src(1, 8'h50, 1'b1);
        expect_w(4'b0001, 8'hA0);
        for (int b = 0; b < 4; b++) expect_w(4'b0001, 8'(8'h40 + b));
        expect_w(4'b0010, 8'hA1);
        expect_w(4'b0010, 8'h50);
        expect_w(4'b0001, 8'hA0);
        for (int b = 4; b < 8; b++) expect_w(4'b0001, 8'(8'h40 + b));
        expect_w(4'b0001, 8'hA0);
        expect_w(4'b0001, 8'h48);
        expect_w(4'b0001, 8'h49);
        wait_drain("max_burst", bc);
        check("max_burst_cuts", cut_cnt - cut0, 32'd2);

        // last coinciding with the 4th byte ends the burst without a cut.
        @(posedge clk);
        #1;
        cut0 = cut_cnt;
        for (int b = 0; b < 4; b++) push_src(3, 8'(8'h60 + b), (b == 3) ? 1'b1 : 1'b0);
        expect_w(4'b1000, 8'hA3);
        for (int b = 0; b < 4; b++) expect_w(4'b1000, 8'(8'h60 + b));
        wait_drain("last_at_max", bc);
        check("last_at_max_cut", cut_cnt - cut0, 32'd0);

        // FIFO full for 5 cycles mid-burst.
        @(posedge clk);
        #1;
        push_src(1, 8'h71, 1'b0);
        push_src(1, 8'h72, 1'b0);
        push_src(1, 8'h73, 1'b1);
        expect_w(4'b0010, 8'hA1);
        expect_w(4'b0010, 8'h71);
        expect_w(4'b0010, 8'h72);
        expect_w(4'b0010, 8'h73);
        wait_byte(8'h71);
        @(posedge clk);
        #1 tx_fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("full_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
            check("full_ready", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 tx_fifo_full = 1'b0;
        wait_drain("fifo_full", bc);

        // Granted requester 2 stalls 3 cycles while requester 3 waits.
        @(posedge clk);
        #1;
        push_src(2, 8'h81, 1'b0);
        push_src(2, 8'h82, 1'b0);
        push_src(2, 8'h83, 1'b1);
        push_src(3, 8'h90, 1'b1);
        expect_w(4'b0100, 8'hA2);
        expect_w(4'b0100, 8'h81);
        expect_w(4'b0100, 8'h82);
        expect_w(4'b0100, 8'h83);
        expect_w(4'b1000, 8'hA3);
        expect_w(4'b1000, 8'h90);
        wait_byte(8'h81);
        @(posedge clk);
        #1 en[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
            check("stall_ready3", {31'd0, req_ready[3]}, 32'd0);
            check("stall_grant", {28'd0, grant}, 32'h4);
        end
        @(posedge clk);
        #1 en[2] = 1'b1;
        wait_drain("stall", bc);

        // Move the pointer to 1, then reset in the middle of requester 2's burst.
        @(posedge clk);
        #1;
        push_src(0, 8'hE0, 1'b1);
        expect_w(4'b0001, 8'hA0);
        expect_w(4'b0001, 8'hE0);
        wait_drain("ptr_setup", bc);
        @(posedge clk);
        #1;
        push_src(2, 8'hB1, 1'b0);
        push_src(2, 8'hB2, 1'b0);
        push_src(2, 8'hB3, 1'b1);
        expect_w(4'b0100, 8'hA2);
        expect_w(4'b0100, 8'hB1);
        wait_byte(8'hB1);
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", {28'd0, grant}, 32'd0);
        check("mid_rst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pending", exp_q.size(), 32'd0);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_src(0, 8'hF0, 1'b1);
        push_src(1, 8'hF1, 1'b1);
        expect_w(4'b0001, 8'hA0);
        expect_w(4'b0001, 8'hF0);
        expect_w(4'b0010, 8'hA1);
        expect_w(4'b0010, 8'hF1);
        wait_drain("after_reset", bc);

        left = 0;
        for (int i = 0; i < 4; i++) left += src_q[i].size();
        check("sources_drained", left, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
